riot_core: RTL and testbench

//  Parametrised RAM-I/O-Timer peripheral for the 6502 bus; next generation of the team's 6530-class block.

---
 rtl/riot_pkg.sv | 37 +++
 rtl/riot_if.sv | 13 +
 rtl/riot_timer.sv | 82 ++++++++
 rtl/riot_core.sv | 138 +++++++++++++
 tb/tb_riot_core.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riot_pkg.sv
// Shared types and constants for the RIOT peripheral: prescaler encoding, register
// select bits and flag positions in the flags register.
package riot_pkg;

    typedef enum logic [1:0] {
        DIV_1    = 2'b00,
        DIV_8    = 2'b01,
        DIV_64   = 2'b10,
        DIV_1024 = 2'b11
    } prescale_e;

    // Register select bits: A[0] in I/O space, A[0] on timer-space reads, A[2] on timer-space writes.
    localparam logic REG_DATA  = 1'b0;
    localparam logic REG_DDR   = 1'b1;
    localparam logic REG_TIMER = 1'b0;
    localparam logic REG_FLAGS = 1'b1;
    localparam logic REG_EDGE  = 1'b0;

    localparam int FLAG_T = 7;
    localparam int FLAG_E = 6;

    function automatic logic [10:0] div_ratio(input prescale_e d);
        case (d)
            DIV_1:   return 11'd1;
            DIV_8:   return 11'd8;
            DIV_64:  return 11'd64;
            default: return 11'd1024;
        endcase
    endfunction

    function automatic logic [9:0] pre_reload(input prescale_e d);
        logic [10:0] r;
        r = div_ratio(d) - 11'd1;
        return r[9:0];
    endfunction

endpackage

// File: rtl/riot_if.sv
// CPU-side bus of the RIOT: select, direction, space, address, data in/out.
interface riot_if #(parameter int ADDR_W = 7);
    logic              cs;
    logic              we_n;
    logic              rs_n;
    logic [ADDR_W-1:0] A;
    logic [7:0]        DI;
    logic [7:0]        DO;
    logic              OE;

    modport master (output cs, we_n, rs_n, A, DI, input DO, OE);
    modport slave  (input cs, we_n, rs_n, A, DI, output DO, OE);
endinterface

// File: rtl/riot_timer.sv
// Interval timer: prescaled 8-bit down-counter that runs free after its first
// underflow and latches an expiry flag.
module riot_timer
    import riot_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load_i,
    input  logic      read_i,
    input  logic [7:0] data_i,
    input  prescale_e div_i,
    input  logic      tie_i,
    output logic [7:0] count_o,
    output logic      tflag_o,
    output logic      tie_o
);

    logic [7:0] count_q, count_d;
    logic [9:0] pre_q, pre_d;
    prescale_e  div_q, div_d;
    logic       expired_q, expired_d;
    logic       tflag_q, tflag_d;
    logic       tie_q, tie_d;
    logic       tick, under;

    always_comb begin
        tick      = expired_q | (pre_q == 10'd0);
        under     = tick & (count_q == 8'h00);
        count_d   = count_q;
        pre_d     = pre_q;
        div_d     = div_q;
        expired_d = expired_q;
        tflag_d   = tflag_q;
        tie_d     = tie_q;
        if (load_i) begin
            count_d   = data_i;
            div_d     = div_i;
            tie_d     = tie_i;
            pre_d     = pre_reload(div_i);
            expired_d = 1'b0;
            tflag_d   = 1'b0;
        end else begin
            if (tick) begin
                count_d = count_q - 8'd1;
                pre_d   = pre_reload(div_q);
            end else begin
                pre_d   = pre_q - 10'd1;
            end
            // A read racing an underflow must not lose the new flag.
            if (under) begin
                expired_d = 1'b1;
                tflag_d   = 1'b1;
            end else if (read_i) begin
                tflag_d   = 1'b0;
            end
            if (read_i) tie_d = tie_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= 8'hFF;
            pre_q     <= pre_reload(DIV_1024);
            div_q     <= DIV_1024;
            expired_q <= 1'b0;
            tflag_q   <= 1'b0;
            tie_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            pre_q     <= pre_d;
            div_q     <= div_d;
            expired_q <= expired_d;
            tflag_q   <= tflag_d;
            tie_q     <= tie_d;
        end
    end

    assign count_o = count_q;
    assign tflag_o = tflag_q;
    assign tie_o   = tie_q;

endmodule

// File: rtl/riot_core.sv
// RAM-I/O-Timer peripheral: internal RAM, NUM_PORTS I/O ports, prescaled timer and
// a port 0 bit 7 edge interrupt, all behind a registered 6502-style read path.
module riot_core
    import riot_pkg::*;
#(
    parameter int RAM_DEPTH = 128,
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 7
) (
    input  logic                   phi2,
    input  logic                   rst,
    riot_if.slave                  bus,
    input  logic [8*NUM_PORTS-1:0] pa_i,
    output logic [8*NUM_PORTS-1:0] pa_o,
    output logic [8*NUM_PORTS-1:0] pa_ddr,
    output logic                   irq
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);

    logic acc_rd, acc_wr, io_sel, tm_sel;
    logic [1:0] port_idx;
    logic [RAM_AW-1:0] ram_addr;

    assign acc_wr   = bus.cs & ~bus.we_n;
    assign acc_rd   = bus.cs & bus.we_n;
    assign io_sel   = bus.rs_n & ~bus.A[4];
    assign tm_sel   = bus.rs_n & bus.A[4];
    assign port_idx = bus.A[2:1];
    assign ram_addr = bus.A[RAM_AW-1:0];

    // RAM is not reset; its contents are undefined after reset anyway.
    logic [7:0] ram_q [RAM_DEPTH];
    always_ff @(posedge phi2) begin
        if (acc_wr && !bus.rs_n) ram_q[ram_addr] <= bus.DI;
    end

    logic [NUM_PORTS-1:0][7:0] pa_o_q, pa_o_d, ddr_q, ddr_d;
    always_comb begin
        pa_o_d = pa_o_q;
        ddr_d  = ddr_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (acc_wr && io_sel && port_idx == 2'(k)) begin
                if (bus.A[0] == REG_DDR) ddr_d[k]  = bus.DI;
                else                     pa_o_d[k] = bus.DI;
            end
        end
    end
    assign pa_o   = pa_o_q;
    assign pa_ddr = ddr_q;

    logic sync1_q, sync2_q, prev_q;
    logic edge_pol_q, edge_pol_d, eie_q, eie_d, eflag_q, eflag_d;
    logic edge_hit, edge_wr, flag_rd;

    assign edge_hit = edge_pol_q ? (sync2_q & ~prev_q) : (~sync2_q & prev_q);
    assign edge_wr  = acc_wr & tm_sel & (bus.A[2] == REG_EDGE);
    assign flag_rd  = acc_rd & tm_sel & (bus.A[0] == REG_FLAGS);

    always_comb begin
        edge_pol_d = edge_wr ? bus.A[0] : edge_pol_q;
        eie_d      = edge_wr ? bus.A[1] : eie_q;
        eflag_d    = edge_hit | (eflag_q & ~flag_rd);
    end

    logic [7:0] count;
    logic tflag, tie;

    riot_timer u_timer (
        .clk     (phi2),
        .rst     (rst),
        .load_i  (acc_wr & tm_sel & (bus.A[2] != REG_EDGE)),
        .read_i  (acc_rd & tm_sel & (bus.A[0] == REG_TIMER)),
        .data_i  (bus.DI),
        .div_i   (prescale_e'(bus.A[1:0])),
        .tie_i   (bus.A[3]),
        .count_o (count),
        .tflag_o (tflag),
        .tie_o   (tie)
    );

    // Unmapped ports fall through to the 8'h00 default.
    logic [7:0] rdata;
    always_comb begin
        rdata = 8'h00;
        if (!bus.rs_n) begin
            rdata = ram_q[ram_addr];
        end else if (!bus.A[4]) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (port_idx == 2'(k)) begin
                    rdata = (bus.A[0] == REG_DDR) ? ddr_q[k]
                          : ((ddr_q[k] & pa_o_q[k]) | (~ddr_q[k] & pa_i[8*k +: 8]));
                end
            end
        end else if (bus.A[0] == REG_FLAGS) begin
            rdata[FLAG_T] = tflag;
            rdata[FLAG_E] = eflag_q;
        end else begin
            rdata = count;
        end
    end

    logic [7:0] do_q, do_d;
    logic       oe_q, oe_d;
    assign do_d = acc_rd ? rdata : do_q;
    assign oe_d = acc_rd;

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            pa_o_q     <= '0;
            ddr_q      <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            edge_pol_q <= 1'b0;
            eie_q      <= 1'b0;
            eflag_q    <= 1'b0;
            do_q       <= 8'h00;
            oe_q       <= 1'b0;
        end else begin
            pa_o_q     <= pa_o_d;
            ddr_q      <= ddr_d;
            sync1_q    <= pa_i[7];
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            edge_pol_q <= edge_pol_d;
            eie_q      <= eie_d;
            eflag_q    <= eflag_d;
            do_q       <= do_d;
            oe_q       <= oe_d;
        end
    end

    assign bus.DO = do_q;
    assign bus.OE = oe_q;
    assign irq    = (tflag & tie) | (eflag_q & eie_q);

endmodule

// File: tb/tb_riot_core.sv
// Bench for riot_core: directed scenarios with literal expectations, then random bus
// traffic, all compared every cycle against a behavioural model of the register map.
module tb_riot_core;
    localparam int RAM_DEPTH = 128;
    localparam int NUM_PORTS = 2;
    localparam int ADDR_W    = 7;

    logic phi2 = 1'b0;
    logic rst  = 1'b1;
    logic [8*NUM_PORTS-1:0] pa_i = '0;
    logic [8*NUM_PORTS-1:0] pa_o, pa_ddr;
    logic irq;

    riot_if #(.ADDR_W(ADDR_W)) bus ();

    riot_core #(.RAM_DEPTH(RAM_DEPTH), .NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W)) dut (
        .phi2   (phi2),
        .rst    (rst),
        .bus    (bus),
        .pa_i   (pa_i),
        .pa_o   (pa_o),
        .pa_ddr (pa_ddr),
        .irq    (irq)
    );

    always #5 phi2 = ~phi2;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] ram_m [RAM_DEPTH];
    bit         ram_ok [RAM_DEPTH];
    logic [7:0] po_m [4];
    logic [7:0] dd_m [4];
    int  t_n, t_r, t_el;       // timer: loaded value, ratio, edges since load
    bit  tie_m, tflag_m;
    bit  pol_m, eie_m, eflag_m;
    bit  hist[$];              // pa_i[7] as sampled on recent edges, newest first
    logic [7:0] exp_do;
    bit  exp_oe, do_known;
    bit  chk_en = 0;

    function automatic int ratio(input logic [1:0] d);
        case (d)
            2'd0: return 1;
            2'd1: return 8;
            2'd2: return 64;
            default: return 1024;
        endcase
    endfunction

    // Count value el edges after loading n with prescale r.
    function automatic int count_of(input int n, input int r, input int el);
        if (el < (n + 1) * r) return n - el / r;
        return 255 - ((el - (n + 1) * r) % 256);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RAM_DEPTH; i++) ram_ok[i] = 0;
        for (int i = 0; i < 4; i++) begin po_m[i] = 8'h00; dd_m[i] = 8'h00; end
        t_n = 255; t_r = 1024; t_el = 0; tie_m = 0; tflag_m = 0;
        pol_m = 0; eie_m = 0; eflag_m = 0;
        hist = {1'b0, 1'b0, 1'b0};
        exp_do = 8'h00; exp_oe = 0; do_known = 1;
    endtask

    task automatic model_step();
        bit rd, wr, known, hit, tread, fread;
        logic [7:0] v;
        logic [ADDR_W-1:0] a;
        int idx, ra, past;
        if (rst) begin model_reset(); return; end
        a  = bus.A;
        rd = bus.cs & bus.we_n;
        wr = bus.cs & ~bus.we_n;
        idx = int'(a[2:1]);
        ra  = int'(a) % RAM_DEPTH;
        tread = rd && bus.rs_n && a[4] && !a[0];
        fread = rd && bus.rs_n && a[4] && a[0];
        v = 8'h00; known = 1;
        if (!bus.rs_n) begin
            v = ram_m[ra]; known = ram_ok[ra];
        end else if (!a[4]) begin
            if (idx < NUM_PORTS)
                v = a[0] ? dd_m[idx] : ((dd_m[idx] & po_m[idx]) | (~dd_m[idx] & pa_i[8*idx +: 8]));
        end else if (a[0]) begin
            v = {tflag_m, eflag_m, 6'b0};
        end else begin
            v = 8'(count_of(t_n, t_r, t_el));
        end
        hit = pol_m ? (hist[1] && !hist[2]) : (!hist[1] && hist[2]);
        hist.push_front(pa_i[7]);
        void'(hist.pop_back());
        if (wr && bus.rs_n && a[4] && a[2]) begin
            t_n = int'(bus.DI); t_r = ratio(a[1:0]); t_el = 0; tie_m = a[3]; tflag_m = 0;
        end else begin
            t_el++;
            past = t_el - (t_n + 1) * t_r;
            if (past >= 0 && past % 256 == 0) tflag_m = 1;
            else if (tread) tflag_m = 0;
            if (tread) tie_m = a[3];
        end
        if (hit) eflag_m = 1;
        else if (fread) eflag_m = 0;
        if (wr && bus.rs_n && a[4] && !a[2]) begin pol_m = a[0]; eie_m = a[1]; end
        if (wr && !bus.rs_n) begin ram_m[ra] = bus.DI; ram_ok[ra] = 1; end
        if (wr && bus.rs_n && !a[4] && idx < NUM_PORTS) begin
            if (a[0]) dd_m[idx] = bus.DI;
            else      po_m[idx] = bus.DI;
        end
        if (rd) begin exp_do = v; do_known = known; end
        exp_oe = rd;
    endtask

    always @(negedge phi2) begin : cmp
        logic [8*NUM_PORTS-1:0] e_o, e_d;
        if (chk_en) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                e_o[8*k +: 8] = po_m[k];
                e_d[8*k +: 8] = dd_m[k];
            end
            check("oe", 32'(bus.OE), 32'(exp_oe));
            if (do_known) check("do", 32'(bus.DO), 32'(exp_do));
            check("irq", 32'(irq), 32'((tflag_m & tie_m) | (eflag_m & eie_m)));
            check("pa_o", 32'(pa_o), 32'(e_o));
            check("pa_ddr", 32'(pa_ddr), 32'(e_d));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge phi2);
        #1 model_step();
        @(posedge phi2);
        #1;
    endtask

    task automatic drive(input bit c, input bit w_n, input bit r_n,
                         input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bus.cs = c; bus.we_n = w_n; bus.rs_n = r_n; bus.A = a; bus.DI = d;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1, 0, '0, 8'h00);
    endtask

    task automatic wr(input bit r_n, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        drive(1, 0, r_n, a, d);
    endtask

    task automatic rd_lit(input string nm, input bit r_n, input logic [ADDR_W-1:0] a,
                          input logic [7:0] exp);
        drive(1, 1, r_n, a, 8'h00);
        check(nm, 32'(bus.DO), 32'(exp));
        check({nm, "_oe"}, 32'(bus.OE), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cs = 0; bus.we_n = 1; bus.rs_n = 0; bus.A = '0; bus.DI = 8'h00;
        model_reset();
        idle(3);
        rst = 1'b0;
        chk_en = 1;
        check("rst_do", 32'(bus.DO), 32'h00);
        check("rst_irq", 32'(irq), 32'd0);
        idle(2);

        // RAM
        wr(0, 7'd3, 8'hA5);
        wr(0, 7'(RAM_DEPTH - 1), 8'h5A);
        rd_lit("ram3", 0, 7'd3, 8'hA5);
        idle(1);
        check("oe_drop", 32'(bus.OE), 32'd0);
        rd_lit("ramtop", 0, 7'(RAM_DEPTH - 1), 8'h5A);

        // Ports
        wr(1, 7'h01, 8'hF0);
        wr(1, 7'h00, 8'hFF);
        pa_i = 16'h000C;
        rd_lit("data0", 1, 7'h00, 8'hFC);
        rd_lit("port3", 1, 7'h06, 8'h00);
        check("pa_o0", 32'(pa_o[7:0]), 32'hFF);
        check("ddr0", 32'(pa_ddr[7:0]), 32'hF0);

        // Timer /1, tie=1
        wr(1, 7'h1C, 8'h03);
        rd_lit("t3", 1, 7'h18, 8'h03);
        rd_lit("t2", 1, 7'h18, 8'h02);
        rd_lit("t1", 1, 7'h18, 8'h01);
        rd_lit("t0", 1, 7'h18, 8'h00);
        check("t_irq", 32'(irq), 32'd1);
        rd_lit("tflags", 1, 7'h11, 8'h80);
        rd_lit("tFE", 1, 7'h18, 8'hFE);
        check("t_irq_clr", 32'(irq), 32'd0);

        // Timer /8
        wr(1, 7'h15, 8'h02);
        idle(22);
        rd_lit("t8_23", 1, 7'h11, 8'h00);
        rd_lit("t8_24", 1, 7'h11, 8'h00);
        rd_lit("t8_25", 1, 7'h11, 8'h80);
        wr(1, 7'h17, 8'hFF);
        rd_lit("t8_reload", 1, 7'h11, 8'h00);

        // Rising edge interrupt
        wr(1, 7'h13, 8'h00);
        pa_i[7] = 1'b1;
        idle(2);
        check("e_irq2", 32'(irq), 32'd0);
        idle(1);
        check("e_irq3", 32'(irq), 32'd1);
        rd_lit("eflag", 1, 7'h11, 8'h40);
        rd_lit("eclr", 1, 7'h11, 8'h00);

        // Reset with flags pending and a read in flight
        wr(1, 7'h01, 8'hAA);
        wr(1, 7'h00, 8'h55);
        wr(1, 7'h12, 8'h00);
        pa_i[7] = 1'b0;
        wr(1, 7'h1C, 8'h01);
        idle(3);
        drive(1, 1, 0, 7'd3, 8'h00);
        check("pre_rst_irq", 32'(irq), 32'd1);
        check("pre_rst_oe", 32'(bus.OE), 32'd1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_irq2", 32'(irq), 32'd0);
        check("rst_oe2", 32'(bus.OE), 32'd0);
        check("rst_do2", 32'(bus.DO), 32'h00);
        check("rst_pa_o", 32'(pa_o), 32'h0);
        check("rst_ddr", 32'(pa_ddr), 32'h0);
        idle(2);
        rst = 1'b0;
        idle(2);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) pa_i = 16'($urandom);
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  7'($urandom),
                  ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 7)));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
